vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout_pkg.sv | 37 +++
 rtl/vga_timing.sv | 62 ++++++
 rtl/vga_scanout.sv | 105 ++++++++++
 tb/tb_vga_scanout.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: 640x480@60 timing constants, pipeline types and address helper
package vga_scanout_pkg;

   localparam int H_VISIBLE   = 640;
   localparam int H_FP        = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BP        = 48;
   localparam int H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_VISIBLE   = 480;
   localparam int V_FP        = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BP        = 33;
   localparam int V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int SCALE_SHIFT = 2;

   localparam int CNT_W  = 10;
   localparam int ADDR_W = 15;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic vis;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

   // y*160 + x with y, x the scan position divided by the 4x scale
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [CNT_W-1:0] h,
                                                    input logic [CNT_W-1:0] v);
      logic [ADDR_W-1:0] x;
      logic [ADDR_W-1:0] y;
      x = ADDR_W'(h >> SCALE_SHIFT);
      y = ADDR_W'(v >> SCALE_SHIFT);
      return (y << 7) + (y << 5) + x;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel enable, h/v scan counters and raw sync/visible decode
module vga_timing
   import vga_scanout_pkg::*;
#(
   parameter int H_VIS    = H_VISIBLE,
   parameter int H_FRONT  = H_FP,
   parameter int H_SYNC_W = H_SYNC,
   parameter int H_TOT    = H_TOTAL,
   parameter int V_VIS    = V_VISIBLE,
   parameter int V_FRONT  = V_FP,
   parameter int V_SYNC_W = V_SYNC,
   parameter int V_TOT    = V_TOTAL
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             pe,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output sync_t            raw,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS_L = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FRONT + H_SYNC_W);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FRONT + V_SYNC_W);

   logic h_end;
   logic v_end;

   assign h_end = h == H_LAST;
   assign v_end = v == V_LAST;

   // pe halves CLOCK_50 to the pixel rate; the scan position steps only on pe edges
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pe <= 1'b0;
         h  <= '0;
         v  <= '0;
      end else begin
         pe <= ~pe;
         if (pe) begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end)
               v <= v_end ? '0 : v + 1'b1;
         end
      end
   end

   // syncs and visible flag for the current scan position, plus the frame-wrap strobe
   always_comb begin
      raw.hs_n = !(h >= HS_BEG && h < HS_END);
      raw.vs_n = !(v >= VS_BEG && v < VS_END);
      raw.vis  = h < H_VIS_L && v < V_VIS_L;
      wrap     = pe && h_end && v_end;
   end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 4x-scaled 160x120 framebuffer scan-out to a 640x480@60 VGA DAC
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int BITS_PER_COLOUR_CHANNEL = 1,
   parameter int H_RES    = 160,
   parameter int V_RES    = 120,
   parameter int H_VIS    = H_VISIBLE,
   parameter int H_FRONT  = H_FP,
   parameter int H_SYNC_W = H_SYNC,
   parameter int H_TOT    = H_TOTAL,
   parameter int V_VIS    = V_VISIBLE,
   parameter int V_FRONT  = V_FP,
   parameter int V_SYNC_W = V_SYNC,
   parameter int V_TOT    = V_TOTAL
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [2:0]        rd_data,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic              VGA_CLK,
   output logic              frame_start
);

   localparam int REP = 8 / BITS_PER_COLOUR_CHANNEL;
   localparam logic [CNT_W-1:0] X_LIM = CNT_W'(H_RES);
   localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(V_RES);

   logic             pe;
   logic             wrap;
   logic             in_fb;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   sync_t            raw;
   sync_t            s1;

   vga_timing #(
      .H_VIS    (H_VIS),
      .H_FRONT  (H_FRONT),
      .H_SYNC_W (H_SYNC_W),
      .H_TOT    (H_TOT),
      .V_VIS    (V_VIS),
      .V_FRONT  (V_FRONT),
      .V_SYNC_W (V_SYNC_W),
      .V_TOT    (V_TOT)
   ) u_timing (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .pe     (pe),
      .h      (h),
      .v      (v),
      .raw    (raw),
      .wrap   (wrap)
   );

   assign in_fb      = raw.vis && (h >> SCALE_SHIFT) < X_LIM && (v >> SCALE_SHIFT) < Y_LIM;
   assign VGA_SYNC_N = 1'b1;
   assign VGA_CLK    = pe;

   // address stage: issue the framebuffer read and hold this pixel's syncs alongside it
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rd_addr <= '0;
         s1      <= SYNC_IDLE;
      end else if (pe) begin
         rd_addr <= in_fb ? pixel_addr(h, v) : '0;
         s1      <= raw;
      end
   end

   // output stage: expand the returned pixel, black it outside the visible area
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else if (pe) begin
         VGA_R       <= s1.vis ? {REP{rd_data[2]}} : '0;
         VGA_G       <= s1.vis ? {REP{rd_data[1]}} : '0;
         VGA_B       <= s1.vis ? {REP{rd_data[0]}} : '0;
         VGA_HS      <= s1.hs_n;
         VGA_VS      <= s1.vs_n;
         VGA_BLANK_N <= s1.vis;
      end
   end

   // frame pulse: one CLOCK_50 cycle after the pe edge that wraps the scan to (0,0)
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)
         frame_start <= 1'b0;
      else
         frame_start <= wrap;
   end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks on a full-timing instance and a shrunken-timing instance
module tb_vga_scanout;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        resetn_a, resetn_b;
   logic [14:0] rd_addr_a, rd_addr_b;
   logic [2:0]  rd_data_a = '0;
   logic [2:0]  rd_data_b = '0;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a;
   logic        hs_b, vs_b, blank_b, sync_b, vclk_b, fs_b;
   logic [2:0]  fb_a [0:19199];

   vga_scanout u_dut (
      .CLOCK_50    (clk),
      .resetn      (resetn_a),
      .rd_addr     (rd_addr_a),
      .rd_data     (rd_data_a),
      .VGA_R       (r_a),
      .VGA_G       (g_a),
      .VGA_B       (b_a),
      .VGA_HS      (hs_a),
      .VGA_VS      (vs_a),
      .VGA_BLANK_N (blank_a),
      .VGA_SYNC_N  (sync_a),
      .VGA_CLK     (vclk_a),
      .frame_start (fs_a)
   );

   vga_scanout #(
      .H_VIS (16), .H_FRONT (2), .H_SYNC_W (4), .H_TOT (24),
      .V_VIS (8),  .V_FRONT (1), .V_SYNC_W (2), .V_TOT (12)
   ) u_small (
      .CLOCK_50    (clk),
      .resetn      (resetn_b),
      .rd_addr     (rd_addr_b),
      .rd_data     (rd_data_b),
      .VGA_R       (r_b),
      .VGA_G       (g_b),
      .VGA_B       (b_b),
      .VGA_HS      (hs_b),
      .VGA_VS      (vs_b),
      .VGA_BLANK_N (blank_b),
      .VGA_SYNC_N  (sync_b),
      .VGA_CLK     (vclk_b),
      .frame_start (fs_b)
   );

   // framebuffers with a one-cycle registered read; the small one is all white
   always @(posedge clk) begin
      rd_data_a <= fb_a[rd_addr_a];
      rd_data_b <= 3'b111;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // cycle after release at which pixel (x,y) is on the outputs / on rd_addr
   function automatic int kp(input int x, input int y);
      return 2 * (y * 800 + x) + 4;
   endfunction

   function automatic int ka(input int x, input int y);
      return 2 * (y * 800 + x) + 2;
   endfunction

   initial begin
      int hs_low, vs_low, vis_n, bad, fs_n, fs_first, fs_second, fs_n_a, fall;
      for (int i = 0; i < 19200; i++) fb_a[i] = 3'b000;
      fb_a[2 * 160 + 3] = 3'b101;
      fb_a[19199]       = 3'b111;
      resetn_a = 1'b0;
      resetn_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_addr", 32'(rd_addr_a), 0);
      check("rst_ctl", 32'({hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a}), 'h34);
      check("rst_rgb", 32'({r_a, g_a, b_a}), 0);

      // shrunken timing: 24x12 ticks per frame, 16x8 visible, all-white framebuffer
      hs_low = 0; vs_low = 0; vis_n = 0; bad = 0; fs_n = 0; fs_first = -1; fs_second = -1;
      resetn_b = 1'b1;
      for (int k = 1; k <= 1200; k++) begin
         @(negedge clk);
         if (fs_b) begin
            fs_n++;
            if (fs_n == 1) fs_first = k;
            else if (fs_n == 2) fs_second = k;
         end
         if (k >= 4 && k <= 578 && k % 2 == 0) begin
            if (!vs_b) vs_low++;
            if (!hs_b && k <= 50) hs_low++;
            if (blank_b) vis_n++;
            if ({r_b, g_b, b_b} != (blank_b ? 24'hFFFFFF : 24'h000000)) bad++;
         end
         if (k == 368) check("s_corner_addr", 32'(rd_addr_b), 163);
         if (k == 370) check("s_corner_px", 32'({blank_b, r_b, g_b, b_b}), 'h1FFFFFF);
         if (k == 372) check("s_past_edge", 32'({blank_b, r_b, g_b, b_b}), 0);
      end
      check("s_vs_low_ticks", vs_low, 48);
      check("s_hs_low_ticks", hs_low, 4);
      check("s_visible_ticks", vis_n, 128);
      check("s_blank_colour", bad, 0);
      check("s_fs_count", fs_n, 2);
      check("s_fs_first", fs_first, 576);
      check("s_fs_second", fs_second, 1152);

      // full 800x525 timing
      hs_low = 0; fs_n_a = 0;
      resetn_a = 1'b1;
      for (int k = 1; k <= kp(300, 12) + 1; k++) begin
         @(negedge clk);
         if (fs_a) fs_n_a++;
         if (k % 2 == 0 && k >= kp(0, 1) && k <= kp(799, 1) && !hs_a) hs_low++;
         if (k == 1) check("pe_rise", 32'(vclk_a), 1);
         if (k == 2) check("addr_p0", 32'(rd_addr_a), 0);
         if (k == 2) check("pipe_fill", 32'({hs_a, vs_a, blank_a}), 6);
         if (k == kp(0, 0)) check("first_px", 32'({hs_a, vs_a, blank_a, vclk_a, r_a, g_a, b_a}), 'hE000000);
         if (k == kp(639, 0)) check("blank_639", 32'(blank_a), 1);
         if (k == kp(640, 0)) check("blank_640", 32'(blank_a), 0);
         if (k == kp(655, 0)) check("hs_655", 32'(hs_a), 1);
         if (k == kp(656, 0)) check("hs_656", 32'(hs_a), 0);
         if (k == kp(751, 0)) check("hs_751", 32'(hs_a), 0);
         if (k == kp(752, 0)) check("hs_752", 32'(hs_a), 1);
         if (k == ka(11, 8)) check("addr_11_8", 32'(rd_addr_a), 322);
         if (k == ka(12, 8)) check("addr_12_8", 32'(rd_addr_a), 323);
         if (k == ka(639, 8)) check("addr_639_8", 32'(rd_addr_a), 479);
         if (k == ka(640, 8)) check("addr_640_8", 32'(rd_addr_a), 0);
         if (k == kp(12, 7)) check("px_12_7", 32'({r_a, g_a, b_a}), 0);
         if (k == kp(11, 8)) check("px_11_8", 32'({r_a, g_a, b_a}), 0);
         if (k == kp(12, 8)) check("px_12_8_clk_lo", 32'({vclk_a, r_a, g_a, b_a}), 'h0FF00FF);
         if (k == kp(12, 8) + 1) check("px_12_8_clk_hi", 32'({vclk_a, r_a, g_a, b_a}), 'h1FF00FF);
         if (k == kp(15, 8)) check("px_15_8", 32'({r_a, g_a, b_a}), 'hFF00FF);
         if (k == kp(16, 8)) check("px_16_8", 32'({r_a, g_a, b_a}), 0);
         if (k == kp(15, 11)) check("px_15_11", 32'({r_a, g_a, b_a}), 'hFF00FF);
         if (k == kp(12, 12)) check("px_12_12", 32'({r_a, g_a, b_a}), 0);
      end
      check("hs_low_ticks", hs_low, 96);
      check("pre_rst", 32'({vclk_a, blank_a, rd_addr_a}), 'h1822B);

      // mid-frame reset at (300,12)
      #3 resetn_a = 1'b0;
      #1 check("async_rst", 32'({rd_addr_a, hs_a, vs_a, blank_a, vclk_a, fs_a}), 'h18);
      check("async_rst_rgb", 32'({r_a, g_a, b_a}), 0);
      repeat (3) @(negedge clk);
      check("rst_hold", 32'({rd_addr_a, hs_a, vs_a, blank_a, vclk_a}), 'hC);
      resetn_a = 1'b1;
      fall = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (fs_a) fs_n_a++;
         if (!hs_a) begin
            fall = k;
            break;
         end
      end
      check("hs_after_rst", fall, 1316);
      check("no_frame_start", fs_n_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
